// File: rtl/fifo_drain.sv
// fifo_drain: drains a DEPTH-entry shift fifo oldest-first onto a valid/ready stream, zero-filling it
module fifo_drain #(
  parameter int DEPTH = 8,
  parameter int BITS  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic                     fifo_en,
  output logic [BITS-1:0]          fifo_d,
  input  logic [BITS-1:0]          fifo_q,
  output logic [BITS-1:0]          out_data,
  output logic [$clog2(DEPTH)-1:0] out_idx,
  output logic                     out_valid,
  input  logic                     out_ready
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);
  typedef enum logic [2:0] {IDLE, CAPTURE, VALID, SHIFT, DONE} state_t;
  state_t r_state, w_state;
  logic [IW-1:0] r_count, w_count, w_idx;
  logic [BITS-1:0] w_data;
  logic w_busy, w_done, w_en, w_valid;
  assign fifo_d = '0;
  // state register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_count   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fifo_en   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
    end else begin
      r_state   <= w_state;
      r_count   <= w_count;
      busy      <= w_busy;
      done      <= w_done;
      fifo_en   <= w_en;
      out_valid <= w_valid;
      out_data  <= w_data;
      out_idx   <= w_idx;
    end
  end
  // next state and next output values; abort outside IDLE overrides start and the handshake
  always_comb begin
    w_state = r_state;
    w_count = r_count;
    w_busy  = busy;
    w_done  = 1'b0;
    w_en    = 1'b0;
    w_valid = out_valid;
    w_data  = out_data;
    w_idx   = out_idx;
    case (r_state)
      IDLE: if (start) begin
        w_state = CAPTURE;
        w_count = '0;
        w_busy  = 1'b1;
      end
      CAPTURE: begin
        w_data  = fifo_q;
        w_idx   = r_count;
        w_valid = 1'b1;
        w_state = VALID;
      end
      VALID: if (out_ready) begin
        w_valid = 1'b0;
        w_en    = 1'b1;
        w_state = SHIFT;
      end
      SHIFT: begin
        w_done  = r_count == LAST;
        w_state = (r_count == LAST) ? DONE : CAPTURE;
        w_count = (r_count == LAST) ? r_count : r_count + IW'(1);
      end
      DONE: begin
        w_busy  = 1'b0;
        w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
    if (abort && r_state != IDLE) begin
      w_state = IDLE;
      w_count = '0;
      w_busy  = 1'b0;
      w_done  = 1'b0;
      w_en    = 1'b0;
      w_valid = 1'b0;
    end
  end
endmodule

// File: tb/tb_fifo_drain.sv
// tb_fifo_drain: fifo_drain against a shift-fifo environment and a word-queue scoreboard
module tb_fifo_drain;
  localparam int D = 8;
  localparam int B = 64;
  localparam int IW = $clog2(D);
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic busy, done, fifo_en, out_valid;
  logic [B-1:0] fifo_d, fifo_q, out_data;
  logic [IW-1:0] out_idx;
  logic [B-1:0] fifo [D];
  logic start2 = 1'b0;
  logic busy2, done2, en2, valid2;
  logic [7:0] d2, q2, data2;
  logic [0:0] idx2;
  logic [7:0] fifo2 [2];
  int n_checks = 0, n_errors = 0;
  always #5 clk = ~clk;

  fifo_drain #(.DEPTH(D), .BITS(B)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .fifo_en(fifo_en), .fifo_d(fifo_d), .fifo_q(fifo_q), .out_data(out_data),
    .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready)
  );
  fifo_drain #(.DEPTH(2), .BITS(8)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(1'b0), .busy(busy2), .done(done2),
    .fifo_en(en2), .fifo_d(d2), .fifo_q(q2), .out_data(data2),
    .out_idx(idx2), .out_valid(valid2), .out_ready(1'b1)
  );

  assign fifo_q = fifo[0];
  assign q2 = fifo2[0];

  // the delay-line fifos being drained: shift toward index 0, shift-in at the top
  always @(posedge clk) begin
    if (fifo_en) begin
      for (int i = 0; i < D - 1; i++) fifo[i] = fifo[i+1];
      fifo[D-1] = fifo_d;
    end
    if (en2) begin
      fifo2[0] = fifo2[1];
      fifo2[1] = d2;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_seq();
    for (int i = 0; i < D; i++) fifo[i] = 64'(i + 1) * 64'h11;
  endtask

  task automatic load_rand();
    for (int i = 0; i < D; i++) fifo[i] = {$urandom, $urandom};
  endtask

  // scoreboard: snapshot of the fifo at start, words must appear in order, one shift per accepted word
  logic m_act = 1'b0, m_en_due = 1'b0, m_done_due = 1'b0, p_stall = 1'b0;
  logic [B-1:0] p_data;
  logic [B-1:0] exp_q [$];
  int k = 0;
  always @(negedge clk) begin
    if (rst) begin
      m_act = 1'b0;
      m_en_due = 1'b0;
      m_done_due = 1'b0;
      p_stall = 1'b0;
      k = 0;
    end else begin
      chk("busy", 64'(busy), 64'(m_act));
      chk("fifo_en", 64'(fifo_en), 64'(m_en_due));
      chk("done", 64'(done), 64'(m_done_due));
      if (!m_act) chk("idle_valid", 64'(out_valid), 64'(0));
      if (p_stall) begin
        chk("hold_valid", 64'(out_valid), 64'(1));
        chk("hold_data", out_data, p_data);
      end
      if (out_valid && k < D) begin
        chk("idx", 64'(out_idx), 64'(k));
        chk("data", out_data, exp_q[k]);
      end
      m_done_due = fifo_en && k == D && !abort;
      m_en_due = out_valid && out_ready && !abort;
      p_stall = out_valid && !out_ready && !abort;
      p_data = out_data;
      if (m_en_due) k++;
      if (m_act && (abort || done)) m_act = 1'b0;
      else if (!m_act && start) begin
        m_act = 1'b1;
        k = 0;
        exp_q = {};
        for (int i = 0; i < D; i++) exp_q.push_back(fifo[i]);
      end
    end
  end

  // one drain started in cycle 0; optional 4-cycle stall, stray restart and abort at given cycles
  task automatic directed(input string tag, input bit pre, input int stall_c, input int restart_c,
                          input int abort_c, input int exp_done, input int exp_en);
    int ens = 0, dcyc = -1;
    logic [B-1:0] acc = '0;
    if (pre) load_seq();
    out_ready = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (fifo_en) ens++;
      if (done) dcyc = c;
      if (out_valid && stall_c > 40) chk({tag, "_vcyc"}, 64'(c), 64'(2 + 3 * int'(out_idx)));
      if (abort_c > 0 && c == abort_c + 1) chk({tag, "_abort_idle"}, 64'(busy), 64'(0));
      start = (c == restart_c);
      abort = (c == abort_c);
      out_ready = !(c >= stall_c && c < stall_c + 4);
    end
    chk({tag, "_done_cyc"}, 64'(dcyc), 64'(exp_done));
    chk({tag, "_en_pulses"}, 64'(ens), 64'(exp_en));
    if (exp_en == D) begin
      for (int i = 0; i < D; i++) acc |= fifo[i];
      chk({tag, "_fifo_zero"}, acc, 64'(0));
    end
  endtask

  initial begin
    int nv;
    load_seq();
    fifo2[0] = 8'hA5;
    fifo2[1] = 8'h5A;
    repeat (2) step();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_en", 64'(fifo_en), 64'(0));
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_data", out_data, 64'(0));
    chk("rst_idx", 64'(out_idx), 64'(0));
    chk("fifo_d", fifo_d, 64'(0));
    rst = 1'b0;
    step();
    nv = 0;
    start2 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      start2 = 1'b0;
      if (valid2) begin
        nv++;
        chk("t6_data", 64'(data2), nv == 1 ? 64'hA5 : 64'h5A);
        chk("t6_vcyc", 64'(c), nv == 1 ? 64'(2) : 64'(5));
      end
      if (done2) chk("t6_done_cyc", 64'(c), 64'(7));
    end
    chk("t6_words", 64'(nv), 64'(2));
    chk("t6_fifo_zero", 64'({fifo2[0], fifo2[1]}), 64'(0));
    directed("t1", 1'b1, 999, 0, 0, 25, 8);
    directed("t2", 1'b1, 11, 0, 0, 29, 8);
    directed("t3", 1'b1, 999, 7, 0, 25, 8);
    directed("t4", 1'b1, 999, 0, 9, -1, 3);
    chk("t4_fifo_q", fifo_q, 64'h44);
    directed("t4b", 1'b0, 999, 0, 0, 25, 8);
    load_seq();
    out_ready = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      start = 1'b0;
      out_ready = (c < 11);
    end
    chk("t5_valid_before", 64'(out_valid), 64'(1));
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 64'(out_valid), 64'(0));
    chk("t5_rst_busy", 64'(busy), 64'(0));
    chk("t5_rst_data", out_data, 64'(0));
    chk("t5_rst_idx", 64'(out_idx), 64'(0));
    chk("t5_rst_en", 64'(fifo_en), 64'(0));
    out_ready = 1'b1;
    step();
    rst = 1'b0;
    step();
    directed("t5b", 1'b0, 999, 0, 0, 25, 8);
    for (int r = 0; r < 20; r++) begin
      int c;
      load_rand();
      start = 1'b1;
      out_ready = 1'b1;
      for (c = 0; c < 500; c++) begin
        step();
        if (!busy) break;
        start = ($urandom_range(0, 9) == 0);
        abort = ($urandom_range(0, 149) == 0);
        out_ready = ($urandom_range(0, 3) != 0);
      end
      start = 1'b0;
      abort = 1'b0;
      chk("rand_timeout", 64'(c < 500), 64'(1));
    end
    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
